// File: rtl/data_ram_hs.sv
// rtl/data_ram_hs.sv - byte-writable word RAM behind a valid/ready request/response handshake
module data_ram_hs #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_W/8-1:0]   req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    input  logic [ADDR_W-1:0]     test_addr,
    output logic [DATA_W-1:0]     test_data,
    output logic                  busy
);

    localparam int              NBYTES    = DATA_W / 8;
    localparam int              MEM_WORDS = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT  = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [NBYTES-1:0] wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merged;
    logic              addr_ok;
    logic              access;

    // Words at or above DEPTH are never written and never read back, so they trim away.
    logic [DATA_W-1:0] mem [MEM_WORDS];

    assign addr_ok    = {1'b0, addr_q} < DEPTH_LIM;
    assign access     = (state == S_WAIT) && (cnt == 4'd0);
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign test_data  = ({1'b0, test_addr} < DEPTH_LIM) ? mem[test_addr] : '0;

    // Overlay enabled bytes of the captured write data onto the stored word.
    always_comb begin
        merged = mem[addr_q];
        for (int i = 0; i < NBYTES; i++) begin
            if (wen_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Request capture, latency countdown, response hold and handshake sequencing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            wen_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CNT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_rdata <= addr_ok ? merged : '0;
                        resp_err   <= !addr_ok;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory commit; a reset forces IDLE asynchronously, which cancels any pending write.
    always_ff @(posedge clk) begin
        if (access && addr_ok && (|wen_q)) begin
            mem[addr_q] <= merged;
        end
    end

endmodule

// File: tb/tb_data_ram_hs.sv
// tb/tb_data_ram_hs.sv - scoreboard bench for data_ram_hs with random traffic and directed corners
module tb_data_ram_hs;

    localparam int DEPTH = 20;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_wen = '0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [4:0]  test_addr = '0;
    logic [31:0] test_data;
    logic        busy;

    logic        lv [2];
    logic        lrdy [2];
    logic [3:0]  lwen [2];
    logic [4:0]  laddr [2];
    logic [31:0] lwd [2];
    logic        lrv [2];
    logic        lrr [2];
    logic [31:0] lrd [2];
    logic        lerr [2];
    logic [4:0]  lta [2];
    logic [31:0] ltd [2];
    logic        lbusy [2];

    always #5 clk = ~clk;

    data_ram_hs #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .test_addr(test_addr), .test_data(test_data), .busy(busy)
    );

    data_ram_hs #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .resetn(resetn), .req_valid(lv[0]), .req_ready(lrdy[0]),
        .req_wen(lwen[0]), .req_addr(laddr[0]), .req_wdata(lwd[0]),
        .resp_valid(lrv[0]), .resp_ready(lrr[0]), .resp_rdata(lrd[0]),
        .resp_err(lerr[0]), .test_addr(lta[0]), .test_data(ltd[0]), .busy(lbusy[0])
    );

    data_ram_hs #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .LATENCY(15)) u_lat15 (
        .clk(clk), .resetn(resetn), .req_valid(lv[1]), .req_ready(lrdy[1]),
        .req_wen(lwen[1]), .req_addr(laddr[1]), .req_wdata(lwd[1]),
        .resp_valid(lrv[1]), .resp_ready(lrr[1]), .resp_rdata(lrd[1]),
        .resp_err(lerr[1]), .test_addr(lta[1]), .test_data(ltd[1]), .busy(lbusy[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t_due;
    } exp_t;

    exp_t        sb [$];
    exp_t        cur;
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hold = 0;
    logic        active = 1'b0;
    logic        expect_idle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random readiness with optional forced stall windows.
    always @(posedge clk) begin
        #1;
        if (hold > 0) begin
            resp_ready = 1'b0;
            hold--;
        end else begin
            resp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops the scoreboard on each new response and checks it is held under backpressure.
    always @(negedge clk) begin
        if (resetn) begin
            if (expect_idle) begin
                check("idle_after_handshake", {30'd0, req_ready, resp_valid}, 32'd2);
                expect_idle = 1'b0;
            end
            if (resp_valid) begin
                if (!active) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        active = 1'b1;
                        check("resp_latency", cyc, cur.t_due);
                        check("resp_rdata", resp_rdata, cur.rdata);
                        check("resp_err", {31'd0, resp_err}, {31'd0, cur.err});
                        check("test_data_commit", test_data, cur.rdata);
                    end
                end else begin
                    check("hold_rdata", resp_rdata, cur.rdata);
                    check("hold_err", {31'd0, resp_err}, {31'd0, cur.err});
                end
                check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                check("busy_in_resp", {31'd0, busy}, 32'd1);
                if (resp_ready) begin
                    active = 1'b0;
                    expect_idle = 1'b1;
                end
            end
        end
    end

    task automatic do_req(input logic [3:0] wen, input logic [4:0] addr, input logic [31:0] wd);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready) begin
            n++;
            if (n > 200) begin
                check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        e.t_due   = cyc + 1 + LAT;
        if (int'(addr) < DEPTH) begin
            e.rdata = merge(model[addr], wd, wen);
            e.err   = 1'b0;
            model[addr] = e.rdata;
        end else begin
            e.rdata = '0;
            e.err   = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = 4'($urandom);
        req_addr  = 5'($urandom);
        req_wdata = $urandom;
        test_addr = addr;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (sb.size() != 0 || active || !req_ready) begin
            n++;
            if (n > 300) begin
                check("drain_timeout", sb.size(), 0);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic peek(input logic [4:0] a);
        test_addr = a;
        #1;
        check("test_port", test_data, (int'(a) < DEPTH) ? model[a] : 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            lv[k] = 1'b0; lwen[k] = '0; laddr[k] = '0; lwd[k] = '0;
            lrr[k] = 1'b1; lta[k] = '0;
        end
        for (int a = 0; a < 32; a++) model[a] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // LATENCY=1 and LATENCY=15 instances: count edges from acceptance to resp_valid.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            lv[k] = 1'b1; lwen[k] = 4'hF; laddr[k] = 5'(k + 9); lwd[k] = 32'hA5A50000 + k;
            @(posedge clk);
            #1;
            lv[k] = 1'b0;
            n = 0;
            while (!lrv[k] && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("latency_sweep", n, (k == 0) ? 32'd1 : 32'd15);
            check("lat_rdata", lrd[k], 32'hA5A50000 + k);
            check("lat_err", {31'd0, lerr[k]}, 32'd0);
            check("lat_busy", {30'd0, lbusy[k], lrdy[k]}, 32'd2);
            lta[k] = 5'(k + 9);
            #1;
            check("lat_test_data", ltd[k], 32'hA5A50000 + k);
        end

        for (int a = 0; a < DEPTH; a++) do_req(4'hF, 5'(a), $urandom);
        wait_idle();

        // Full write then read back.
        do_req(4'hF, 5'd3, 32'h12345678);
        do_req(4'h0, 5'd3, 32'hFFFFFFFF);
        wait_idle();
        test_addr = 5'd3;
        #1;
        check("write_read_addr3", test_data, 32'h12345678);

        // Single-byte merge into a cleared word.
        do_req(4'hF, 5'd3, 32'h00000000);
        do_req(4'b0001, 5'd3, 32'hFFFFFFFF);
        wait_idle();
        test_addr = 5'd3;
        #1;
        check("byte_merge_addr3", test_data, 32'h000000FF);

        // Out-of-range write must leave every in-range word alone.
        do_req(4'hF, 5'd25, 32'hCAFEF00D);
        wait_idle();
        peek(5'd25);
        for (int a = 0; a < DEPTH; a++) peek(5'(a));

        // Long stall on a response.
        hold = LAT + 8;
        do_req(4'h0, 5'd5, 32'd0);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            do_req(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                   5'($urandom_range(0, 31)), $urandom);
            if ((i % 10) == 0) begin
                wait_idle();
                peek(5'($urandom_range(0, 31)));
            end
        end
        wait_idle();

        // Reset while a write to addr 7 is still counting down.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 4'hF; req_addr = 5'd7; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_wait");
        repeat (4) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        peek(5'd7);

        do_req(4'h0, 5'd7, 32'd0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_hs.md
DATA_RAM_HS -- requirements
Module: data_ram_hs

Interface
REQ-001 Parameter DATA_W, default 32, data word width; SHALL be a multiple of 8, at least 8.
REQ-002 Parameter ADDR_W, default 5, word-address width.
REQ-003 Parameter DEPTH, default 32, number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to access; legal range 1..15.
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge only.
REQ-006 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port req_valid, input, 1 bit: request present.
REQ-008 Port req_ready, output, 1 bit: block can accept a request.
REQ-009 Port req_wen, input, DATA_W/8 bits: per-byte write enables; all-zero means read.
REQ-010 Port req_addr, input, ADDR_W bits: word address.
REQ-011 Port req_wdata, input, DATA_W bits: write data.
REQ-012 Port resp_valid, output, 1 bit: response present.
REQ-013 Port resp_ready, input, 1 bit: consumer accepts the response.
REQ-014 Port resp_rdata, output, DATA_W bits: word read, or the merged word after a write.
REQ-015 Port resp_err, output, 1 bit: the address was out of range (>= DEPTH).
REQ-016 Port test_addr, input, ADDR_W bits: debug read address.
REQ-017 Port test_data, output, DATA_W bits: debug read data, combinational.
REQ-018 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and resp_valid SHALL be 1 only in RESP.
REQ-020 IDLE: on req_valid=1 at an edge, the block SHALL capture req_wen/req_addr/req_wdata, load cnt=LATENCY-1 (4-bit counter) and enter WAIT.
REQ-021 WAIT: each edge with cnt!=0 SHALL decrement cnt; the edge with cnt==0 SHALL perform the access and enter RESP.
REQ-022 Timing: for a request accepted at edge T0, the access and the rise of resp_valid SHALL occur at edge T0+LATENCY.
REQ-023 Write access: each byte i with wen[i]=1 SHALL be written from wdata, and other bytes SHALL be kept; resp_rdata SHALL hold the merged word.
REQ-024 Read access (wen=0): resp_rdata SHALL be registered from mem[addr], and memory SHALL be unchanged.
REQ-025 Out of range (addr >= DEPTH): no write SHALL occur, resp_rdata SHALL be 0 and resp_err SHALL be 1; otherwise resp_err SHALL be 0.
REQ-026 RESP: resp_rdata and resp_err SHALL hold stable while resp_valid=1 and resp_ready=0; the edge with resp_ready=1 SHALL return the FSM to IDLE.
REQ-027 A request SHALL NOT be accepted in the same cycle as a response handshake; maximum throughput SHALL be one request per LATENCY+2 cycles.
REQ-028 Changes to req_* after acceptance SHALL have no effect on the in-flight operation.
REQ-029 test_data SHALL equal mem[test_addr] combinationally, reflecting a write from the edge it commits; test_data SHALL be 0 when test_addr >= DEPTH.
REQ-030 The test port SHALL NOT affect the FSM or memory contents.

Reset
REQ-031 resetn=0 SHALL immediately force state IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0 and busy=0; req_ready SHALL be 1 while resetn=0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 A reset in WAIT before the commit edge SHALL discard the pending write, leaving memory unchanged; a reset in RESP SHALL drop the response.

Verification
REQ-034 Full write, then read: write addr 3, wen=4'hF, wdata=32'h12345678 accepted at T0 -> resp_valid at T0+2 with rdata 12345678; a read of addr 3 SHALL return 12345678 with err=0.
REQ-035 Byte merge: addr 3 holds 32'h00000000; write wen=4'b0001, wdata=32'hFFFFFFFF -> resp_rdata=32'h000000FF, and test_data at test_addr=3 SHALL equal 000000FF.
REQ-036 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err SHALL stay stable with req_ready=0; release -> IDLE on the next edge.
REQ-037 Out of range: DEPTH=20, write addr 25 -> resp_err=1, rdata=0; test_data at addr 25 SHALL be 0, and no in-range word SHALL change.
REQ-038 Reset mid-WAIT: LATENCY=4, write addr 7 = 32'hDEADBEEF, pulse resetn low at T0+2 -> outputs go to reset values immediately; mem[7] SHALL be unchanged per test_data.
REQ-039 Latency sweep: LATENCY=1 and LATENCY=15 -> resp_valid SHALL rise exactly at T0+1 and T0+15 respectively.
